// File: rtl/ciphertext_poly_multiply_if.sv
// Coefficient stream bundle for the ciphertext polynomial multiplier:
// one valid/ready input stream (operands A then B) and one output stream.
interface ciphertext_poly_multiply_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ciphertext_poly_multiply.sv
// Streaming modular polynomial multiplier: load A, multiply-accumulate each
// B coefficient against all of A in one cycle, then drain the product.
module ciphertext_poly_multiply #(
  parameter int CIPHERTEXT_WIDTH   = 10,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int DIMENSION          = 1,
  parameter int NEGACYCLIC         = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  ciphertext_poly_multiply_if.slave    bus,
  output logic                         busy,
  output logic                         err
);

  localparam int CW   = CIPHERTEXT_WIDTH;
  localparam int NA   = DIMENSION + 1;
  localparam int NOUT = (NEGACYCLIC != 0) ? NA : (2 * DIMENSION + 1);
  localparam int CNTW = (NOUT > 1) ? $clog2(NOUT) : 1;

  localparam logic [CW+1:0]   QL = (CW+2)'(CIPHERTEXT_MODULUS);
  localparam logic [2*CW-1:0] QM = (2*CW)'(CIPHERTEXT_MODULUS);

  typedef enum logic [1:0] {LOAD_A, MAC_B, DRAIN} state_e;

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [CW-1:0]   a_q   [NA];
  logic [CW-1:0]   acc_q [NOUT];
  logic [CW-1:0]   acc_d [NOUT];
  logic [CW-1:0]   prodMod [NA];
  logic [CW-1:0]   bMod;
  logic [CW-1:0]   outData_q;
  logic            inReady_q;
  logic            outValid_q;
  logic            outLast_q;
  logic            busy_q;
  logic            err_q;
  logic            inFire;
  logic            outFire;
  logic            lastBeat;

  function automatic logic [CW-1:0] modq(input logic [2*CW-1:0] x);
    logic [2*CW-1:0] r;
    r = x % QM;
    return r[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] addq(input logic [CW-1:0] a, input logic [CW-1:0] p);
    logic [CW+1:0] s;
    s = {2'b00, a} + {2'b00, p};
    if (s >= QL) s = s - QL;
    return s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] subq(input logic [CW-1:0] a, input logic [CW-1:0] p);
    logic [CW+1:0] s;
    s = {2'b00, a} + QL - {2'b00, p};
    if (s >= QL) s = s - QL;
    return s[CW-1:0];
  endfunction

  assign inFire   = bus.in_valid && inReady_q;
  assign outFire  = outValid_q && bus.out_ready;
  assign lastBeat = (cnt_q == CNTW'(DIMENSION));

  // Output o collects a[i]*b[j] for i+j==o; in negacyclic mode the terms
  // with i+j past DIMENSION fold back to o = i+j-NA with a negative sign.
  always_comb begin
    bMod = modq({{CW{1'b0}}, bus.in_data});
    for (int i = 0; i < NA; i++) begin
      prodMod[i] = modq({{CW{1'b0}}, a_q[i]} * {{CW{1'b0}}, bMod});
    end
    acc_d = acc_q;
    for (int o = 0; o < NOUT; o++) begin
      for (int i = 0; i < NA; i++) begin
        if (o >= i && (o - i) <= DIMENSION) begin
          if (cnt_q == CNTW'(o - i)) acc_d[o] = addq(acc_d[o], prodMod[i]);
        end else if (NEGACYCLIC != 0 && o < i) begin
          if (cnt_q == CNTW'(o - i + NA)) acc_d[o] = subq(acc_d[o], prodMod[i]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD_A;
      cnt_q      <= '0;
      for (int i = 0; i < NA; i++)   a_q[i]   <= '0;
      for (int o = 0; o < NOUT; o++) acc_q[o] <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Protocol errors are only flagged; operand boundaries come from cnt_q.
      if (inFire && (bus.in_last != lastBeat)) err_q <= 1'b1;
      case (state_q)
        LOAD_A: begin
          if (inFire) begin
            for (int i = 0; i < NA; i++) begin
              if (cnt_q == CNTW'(i)) a_q[i] <= bMod;
            end
            busy_q <= 1'b1;
            if (lastBeat) begin
              cnt_q   <= '0;
              for (int o = 0; o < NOUT; o++) acc_q[o] <= '0;
              state_q <= MAC_B;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        MAC_B: begin
          if (inFire) begin
            acc_q <= acc_d;
            if (lastBeat) begin
              cnt_q      <= '0;
              inReady_q  <= 1'b0;
              outValid_q <= 1'b1;
              outData_q  <= acc_d[0];
              outLast_q  <= (NOUT == 1);
              state_q    <= DRAIN;
            end else begin
              cnt_q <= cnt_q + CNTW'(1);
            end
          end
        end
        DRAIN: begin
          if (outFire) begin
            if (cnt_q == CNTW'(NOUT - 1)) begin
              cnt_q      <= '0;
              outValid_q <= 1'b0;
              outLast_q  <= 1'b0;
              inReady_q  <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= LOAD_A;
            end else begin
              for (int o = 1; o < NOUT; o++) begin
                if (cnt_q == CNTW'(o - 1)) outData_q <= acc_q[o];
              end
              outLast_q <= (cnt_q == CNTW'(NOUT - 2));
              cnt_q     <= cnt_q + CNTW'(1);
            end
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign busy          = busy_q;
  assign err           = err_q;

endmodule

// File: tb/tb_ciphertext_poly_multiply.sv
// Scoreboard bench for ciphertext_poly_multiply: three instances (default
// linear, q=97/CW=7, negacyclic) checked against a reference product model.
module tb_ciphertext_poly_multiply;

  typedef struct packed {
    logic [9:0] d;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       inValid  [3];
  logic [9:0] inData   [3];
  logic       inLast   [3];
  logic       outReady [3];
  logic       inReadyA [3];
  logic       outValidA[3];
  logic       outLastA [3];
  logic [9:0] outDataA [3];
  logic       busyA    [3];
  logic       errA     [3];
  int         readyMode[3];
  int         outCount [3];
  exp_t       expQ     [3][$];
  int         checks;
  int         errors;

  ciphertext_poly_multiply_if #(.DATA_WIDTH(10)) if0 ();
  ciphertext_poly_multiply_if #(.DATA_WIDTH(7))  if1 ();
  ciphertext_poly_multiply_if #(.DATA_WIDTH(10)) if2 ();

  ciphertext_poly_multiply #(
    .CIPHERTEXT_WIDTH(10), .CIPHERTEXT_MODULUS(1024), .DIMENSION(1), .NEGACYCLIC(0)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave), .busy(busyA[0]), .err(errA[0]));

  ciphertext_poly_multiply #(
    .CIPHERTEXT_WIDTH(7), .CIPHERTEXT_MODULUS(97), .DIMENSION(1), .NEGACYCLIC(0)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave), .busy(busyA[1]), .err(errA[1]));

  ciphertext_poly_multiply #(
    .CIPHERTEXT_WIDTH(10), .CIPHERTEXT_MODULUS(1024), .DIMENSION(1), .NEGACYCLIC(1)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave), .busy(busyA[2]), .err(errA[2]));

  assign if0.in_valid  = inValid[0];
  assign if0.in_data   = inData[0];
  assign if0.in_last   = inLast[0];
  assign if0.out_ready = outReady[0];
  assign inReadyA[0]   = if0.in_ready;
  assign outValidA[0]  = if0.out_valid;
  assign outDataA[0]   = if0.out_data;
  assign outLastA[0]   = if0.out_last;

  assign if1.in_valid  = inValid[1];
  assign if1.in_data   = inData[1][6:0];
  assign if1.in_last   = inLast[1];
  assign if1.out_ready = outReady[1];
  assign inReadyA[1]   = if1.in_ready;
  assign outValidA[1]  = if1.out_valid;
  assign outDataA[1]   = {3'b000, if1.out_data};
  assign outLastA[1]   = if1.out_last;

  assign if2.in_valid  = inValid[2];
  assign if2.in_data   = inData[2];
  assign if2.in_last   = inLast[2];
  assign if2.out_ready = outReady[2];
  assign inReadyA[2]   = if2.in_ready;
  assign outValidA[2]  = if2.out_valid;
  assign outDataA[2]   = if2.out_data;
  assign outLastA[2]   = if2.out_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference model for DIMENSION=1 products, reduced into [0,q).
  task automatic pushExpected(input int s, input int q, input bit neg,
                              input int a0, input int a1, input int b0, input int b1);
    longint x0, x1, y0, y1, c0, c1, c2;
    exp_t e;
    x0 = a0 % q; x1 = a1 % q; y0 = b0 % q; y1 = b1 % q;
    c1 = (x0 * y1 + x1 * y0) % q;
    c2 = (x1 * y1) % q;
    c0 = neg ? ((((x0 * y0) - (x1 * y1)) % q) + q) % q : (x0 * y0) % q;
    e.d = 10'(c0); e.last = 1'b0;  expQ[s].push_back(e);
    e.d = 10'(c1); e.last = neg;   expQ[s].push_back(e);
    if (!neg) begin
      e.d = 10'(c2); e.last = 1'b1; expQ[s].push_back(e);
    end
  endtask

  task automatic sendBeat(input int s, input int data, input bit last);
    bit fired;
    fired       = 1'b0;
    inValid[s]  = 1'b1;
    inData[s]   = 10'(data);
    inLast[s]   = last;
    for (int c = 0; c < 200 && !fired; c++) begin
      fired = inReadyA[s];
      @(posedge clk); #1;
    end
    if (!fired) checkOutput($sformatf("dut%0d in_ready timeout", s), 0, 1);
  endtask

  // lastBits order: {B1, B0, A1, A0}; 4'b1010 is the well-formed pattern.
  task automatic applyStimulus(input int s, input int q, input bit neg,
                               input int a0, input int a1, input int b0, input int b1,
                               input logic [3:0] lastBits, input bit chain);
    pushExpected(s, q, neg, a0, a1, b0, b1);
    sendBeat(s, a0, lastBits[0]);
    sendBeat(s, a1, lastBits[1]);
    sendBeat(s, b0, lastBits[2]);
    sendBeat(s, b1, lastBits[3]);
    if (!chain) inValid[s] = 1'b0;
  endtask

  task automatic waitDrain(input int s);
    for (int c = 0; c < 300 && expQ[s].size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checkOutput($sformatf("dut%0d drain pending", s), expQ[s].size(), 0);
  endtask

  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 3; s++) begin
      case (readyMode[s])
        1:       outReady[s] = 1'($urandom_range(0, 1));
        2:       outReady[s] = 1'b0;
        default: outReady[s] = 1'b1;
      endcase
    end
  end

  // Every cycle with out_valid is compared to the queue head, so a stalled
  // beat must hold its value; the head is retired only on a transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int s = 0; s < 3; s++) begin
        if (outValidA[s]) begin
          if (expQ[s].size() == 0) begin
            checkOutput($sformatf("dut%0d unexpected out_valid", s), 1, 0);
          end else begin
            checkOutput($sformatf("dut%0d out_data", s), outDataA[s], expQ[s][0].d);
            checkOutput($sformatf("dut%0d out_last", s), outLastA[s], expQ[s][0].last);
            if (outReady[s]) begin
              void'(expQ[s].pop_front());
              outCount[s]++;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int startCount;
    checks = 0;
    errors = 0;
    for (int s = 0; s < 3; s++) begin
      inValid[s] = 1'b0; inData[s] = '0; inLast[s] = 1'b0;
      outReady[s] = 1'b1; readyMode[s] = 0; outCount[s] = 0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", inReadyA[0], 1);
    checkOutput("reset out_valid", outValidA[0], 0);
    checkOutput("reset out_last", outLastA[0], 0);
    checkOutput("reset out_data", outDataA[0], 0);
    checkOutput("reset busy", busyA[0], 0);
    checkOutput("reset err", errA[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] linear product A=[3,5] B=[7,2]");
    sendBeat(0, 3, 1'b0);
    checkOutput("busy after first A beat", busyA[0], 1);
    inValid[0] = 1'b0;
    pushExpected(0, 1024, 1'b0, 3, 5, 7, 2);
    sendBeat(0, 5, 1'b1);
    sendBeat(0, 7, 1'b0);
    sendBeat(0, 2, 1'b1);
    inValid[0] = 1'b0;
    checkOutput("in_ready low in drain", inReadyA[0], 0);
    checkOutput("out_valid right after final B", outValidA[0], 1);
    waitDrain(0);
    checkOutput("in_ready after drain", inReadyA[0], 1);
    checkOutput("busy after drain", busyA[0], 0);

    $display("[TB] q=97 and negacyclic instances");
    applyStimulus(1, 97, 1'b0, 50, 60, 40, 30, 4'b1010, 1'b0);
    waitDrain(1);
    applyStimulus(2, 1024, 1'b1, 3, 5, 7, 2, 4'b1010, 1'b0);
    waitDrain(2);
    applyStimulus(2, 1024, 1'b1, 0, 1, 0, 1, 4'b1010, 1'b0);
    waitDrain(2);

    $display("[TB] wrap and back-to-back operations");
    applyStimulus(0, 1024, 1'b0, 1000, 0, 3, 0, 4'b1010, 1'b1);
    applyStimulus(0, 1024, 1'b0, 3, 5, 7, 2, 4'b1010, 1'b1);
    applyStimulus(0, 1024, 1'b0, 1023, 1023, 1023, 1023, 4'b1010, 1'b0);
    waitDrain(0);

    $display("[TB] backpressure");
    startCount = outCount[0];
    applyStimulus(0, 1024, 1'b0, 50, 60, 40, 30, 4'b1010, 1'b0);
    for (int c = 0; c < 50 && outCount[0] == startCount; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("first output before stall", 32'(outCount[0] != startCount), 1);
    readyMode[0] = 2;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("out_valid held during stall", outValidA[0], 1);
    checkOutput("in_ready low during stall", inReadyA[0], 0);
    readyMode[0] = 0;
    waitDrain(0);
    readyMode[0] = 1;
    applyStimulus(0, 1024, 1'b0, 3, 5, 7, 2, 4'b1010, 1'b0);
    waitDrain(0);
    readyMode[0] = 0;
    @(posedge clk); #1;

    $display("[TB] reset during MAC_B");
    sendBeat(0, 9, 1'b0);
    sendBeat(0, 11, 1'b1);
    sendBeat(0, 13, 1'b0);
    inValid[0] = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("mid-op reset out_valid", outValidA[0], 0);
    checkOutput("mid-op reset busy", busyA[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(0, 1024, 1'b0, 3, 5, 7, 2, 4'b1010, 1'b0);
    waitDrain(0);
    checkOutput("err after clean reload", errA[0], 0);

    $display("[TB] in_last protocol error");
    applyStimulus(0, 1024, 1'b0, 3, 5, 7, 2, 4'b1011, 1'b0);
    waitDrain(0);
    checkOutput("err after bad in_last", errA[0], 1);
    applyStimulus(0, 1024, 1'b0, 1000, 0, 3, 0, 4'b1010, 1'b0);
    waitDrain(0);
    checkOutput("err sticky", errA[0], 1);
    checkOutput("other instance err", errA[2], 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
